// File: rtl/gol_fb_scanout.sv
// Game-of-Life frame buffer with a raster scanout engine.
// The CPU reads and writes byte cells and a CTRL word on the core's data bus.
// Read data is combinational because the core samples it in the same cycle.
// The display side streams every cell once per frame over valid/ready.
module gol_fb_scanout #(
    parameter int          COLS         = 16,
    parameter int          ROWS         = 16,
    parameter logic [31:0] FB_BASE      = 32'h0000_0400,
    parameter int          BLANK_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             cpu_adr,
    input  logic [31:0]             cpu_wdata,
    input  logic                    cpu_we,
    input  logic [3:0]              cpu_be,
    output logic                    cpu_hit,
    output logic [31:0]             cpu_rdata,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [7:0]              pix_data,
    output logic [$clog2(COLS)-1:0] pix_x,
    output logic [$clog2(ROWS)-1:0] pix_y,
    output logic                    pix_sof,
    output logic                    pix_eol
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int N  = COLS * ROWS;
    localparam int AW = $clog2(N);
    localparam int WW = AW - 2;
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PRESENT,
        S_BLANK
    } state_t;

    // Cell storage: one byte per cell, four cells per bus word (little-endian lanes).
    logic [7:0]    mem_q [N];

    // Scanout control state.
    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    pix_q, pix_d;
    logic [BW-1:0] blank_q, blank_d;
    logic          frame_end;
    logic          last_cell;

    // CTRL word fields.
    logic          scan_en_q;
    logic          frame_done_q;
    logic [15:0]   frame_count_q;

    // Address decode.
    logic          in_blk;
    logic          cell_sel;
    logic          ctrl_sel;
    logic          ctrl_wr;
    logic [WW-1:0] widx;
    logic [31:0]   cell_word;
    logic [31:0]   ctrl_word;
    logic          unused_adr_lsb;

    // The block spans 2*N bytes: the lower half is the cell array, the upper
    // half holds only the CTRL word at its first word address.
    assign in_blk   = (cpu_adr[31:AW+1] == FB_BASE[31:AW+1]);
    assign cell_sel = in_blk & ~cpu_adr[AW];
    assign ctrl_sel = in_blk & cpu_adr[AW] & (cpu_adr[AW-1:2] == '0);
    assign widx     = cpu_adr[AW-1:2];
    assign ctrl_wr  = cpu_we & ctrl_sel & cpu_be[0];
    assign cpu_hit  = cell_sel | ctrl_sel;

    // Byte lanes are selected by cpu_be; the core places the byte itself.
    assign unused_adr_lsb = ^cpu_adr[1:0];

    assign cell_word = {mem_q[{widx, 2'd3}], mem_q[{widx, 2'd2}],
                        mem_q[{widx, 2'd1}], mem_q[{widx, 2'd0}]};
    assign ctrl_word = {8'h00, frame_count_q, 6'h00, frame_done_q, scan_en_q};

    // Combinational read mux; misses return zero.
    always_comb begin
        cpu_rdata = 32'h0;
        if (cell_sel) begin
            cpu_rdata = cell_word;
        end else if (ctrl_sel) begin
            cpu_rdata = ctrl_word;
        end
    end

    // Cell write port: only enabled lanes change, RAM is intentionally not reset.
    always_ff @(posedge clk) begin
        if (cpu_we && cell_sel) begin
            for (int k = 0; k < 4; k++) begin
                if (cpu_be[k]) begin
                    mem_q[{widx, 2'(k)}] <= cpu_wdata[8*k +: 8];
                end
            end
        end
    end

    assign last_cell = (x_q == XW'(COLS - 1)) && (y_q == YW'(ROWS - 1));

    // Scanout next-state logic: one LOAD plus one PRESENT cycle per pixel.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        pix_d     = pix_q;
        blank_d   = blank_q;
        frame_end = 1'b0;
        pix_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (scan_en_q) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // A CPU write to this cell on the same edge lands after the
                // read, so the old value is shown this frame.
                pix_d   = mem_q[{y_q, x_q}];
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                pix_valid = 1'b1;
                if (pix_ready) begin
                    if (last_cell) begin
                        x_d       = '0;
                        y_d       = '0;
                        blank_d   = '0;
                        frame_end = 1'b1;
                        state_d   = S_BLANK;
                    end else begin
                        if (x_q == XW'(COLS - 1)) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                        state_d = S_LOAD;
                    end
                end
            end
            S_BLANK: begin
                // scan_en is only looked at here and in IDLE, so clearing it
                // mid-frame lets the current frame finish.
                if (blank_q == BW'(BLANK_CYCLES - 1)) begin
                    state_d = scan_en_q ? S_LOAD : S_IDLE;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Scanout registers; reset drops pix_valid immediately via the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= 8'h00;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pix_q   <= pix_d;
            blank_q <= blank_d;
        end
    end

    // CTRL register: scan_en RW, frame_done W1C with set priority, frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_en_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'h0000;
        end else begin
            if (ctrl_wr) begin
                scan_en_q <= cpu_wdata[0];
            end
            if (frame_end) begin
                frame_done_q  <= 1'b1;
                frame_count_q <= frame_count_q + 16'd1;
            end else if (ctrl_wr && cpu_wdata[1]) begin
                frame_done_q <= 1'b0;
            end
        end
    end

    assign pix_data = pix_q;
    assign pix_x    = x_q;
    assign pix_y    = y_q;
    assign pix_sof  = pix_valid & (x_q == '0) & (y_q == '0);
    assign pix_eol  = pix_valid & (x_q == XW'(COLS - 1));

endmodule

// File: tb/tb_gol_fb_scanout.sv
// Scoreboard bench for gol_fb_scanout: a byte-array model of the frame buffer
// produces expected pixel streams, a monitor pops and compares each handshake.
module tb_gol_fb_scanout;

    localparam int          COLS  = 16;
    localparam int          ROWS  = 16;
    localparam int          N     = COLS * ROWS;
    localparam int          BLANK = 64;
    localparam logic [31:0] FB    = 32'h0000_0400;
    localparam logic [31:0] CTRL  = FB + N;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic        cpu_hit;
    logic [31:0] cpu_rdata;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic [3:0]  pix_x;
    logic [3:0]  pix_y;
    logic        pix_sof;
    logic        pix_eol;

    gol_fb_scanout #(
        .COLS(COLS), .ROWS(ROWS), .FB_BASE(FB), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_be(cpu_be),
        .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         x;
        int         y;
    } pix_t;

    pix_t       exp_q[$];
    logic [7:0] model [N];
    int         n_checks = 0;
    int         n_fail = 0;
    int         pops = 0;
    int         cyc = 0;
    int         sof_cyc[$];
    int         ready_mode = 0;
    logic       hold = 1'b0;
    logic [7:0] hd;
    int         hx, hy;
    pix_t       e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int w);
        return {model[4*w+3], model[4*w+2], model[4*w+1], model[4*w]};
    endfunction

    task automatic push_frame();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                exp_q.push_back('{model[y*COLS+x], x, y});
    endtask

    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int base;
        @(negedge clk);
        cpu_adr = a; cpu_wdata = d; cpu_be = be; cpu_we = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0; cpu_be = 4'h0; cpu_adr = 32'h0;
        if (a >= FB && a < FB + N) begin
            base = int'(a - FB) & ~3;
            for (int k = 0; k < 4; k++)
                if (be[k]) model[base+k] = d[8*k +: 8];
        end
    endtask

    task automatic cpu_rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        @(negedge clk);
        cpu_adr = a; cpu_we = 1'b0;
        #1;
        d = cpu_rdata;
        h = cpu_hit;
    endtask

    task automatic wait_pops(input int target, input string name);
        int n = 0;
        while (pops < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(pops >= target), 32'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Sink ready pattern: always, 30% random, or stall on cell (3,7).
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ($urandom_range(99) < 30);
            default: pix_ready = !(pix_valid && pix_x == 4'd7 && pix_y == 4'd3);
        endcase
    end

    // Monitor: handshake happens at the next posedge when valid&ready here.
    always @(negedge clk) begin
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 32'(pix_valid), 32'd1);
                check("hold_data", 32'(pix_data), 32'(hd));
                check("hold_x", 32'(pix_x), 32'(hx));
                check("hold_y", 32'(pix_y), 32'(hy));
            end
            hold = 1'b0;
            if (pix_valid) begin
                if (pix_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pixel: got x=%0d y=%0d, expected no pixel", pix_x, pix_y);
                    end else begin
                        e = exp_q.pop_front();
                        check("pix_data", 32'(pix_data), 32'(e.d));
                        check("pix_x", 32'(pix_x), 32'(e.x));
                        check("pix_y", 32'(pix_y), 32'(e.y));
                        check("pix_sof", 32'(pix_sof), 32'(e.x == 0 && e.y == 0));
                        check("pix_eol", 32'(pix_eol), 32'(e.x == COLS - 1));
                        pops++;
                        if (pix_sof) sof_cyc.push_back(cyc);
                    end
                end else begin
                    hold = 1'b1;
                    hd = pix_data;
                    hx = int'(pix_x);
                    hy = int'(pix_y);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        h;
        int          n;
        int          base;
        bit          found;

        cpu_adr = 32'h0; cpu_wdata = 32'h0; cpu_we = 1'b0; cpu_be = 4'h0;
        pix_ready = 1'b0;
        reset = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_pix", {16'h0, pix_data, pix_x, pix_y}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_valid", 32'(pix_valid), 32'd0);
        end
        cpu_rd(CTRL, d, h);
        check("ctrl_reset", d, 32'h0);
        check("ctrl_hit", 32'(h), 32'd1);
        cpu_rd(CTRL + 4, d, h);
        check("miss_hi_hit", 32'(h), 32'd0);
        check("miss_hi_data", d, 32'h0);
        cpu_rd(FB - 4, d, h);
        check("miss_lo_hit", 32'(h), 32'd0);
        check("miss_lo_data", d, 32'h0);

        // Byte store into lane 1
        cpu_wr(FB + 4, 32'h0, 4'hF);
        cpu_wr(FB + 5, 32'h0000_AB00, 4'b0010);
        cpu_rd(FB + 4, d, h);
        check("lw_after_sb", d, 32'h0000_AB00);
        check("cell_hit", 32'(h), 32'd1);
        cpu_rd(FB + 5, d, h);
        check("lbu_lane1", 32'(d[15:8]), 32'h0000_00AB);

        // Fill cell i = i, then a write outside the block must not alias
        for (int w = 0; w < N / 4; w++)
            cpu_wr(FB + 32'(4*w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 4'hF);
        cpu_wr(FB + 2*N, 32'hFFFF_FFFF, 4'hF);
        cpu_rd(FB, d, h);
        check("no_alias", d, model_word(0));

        // Two frames with ready always high
        ready_mode = 0;
        push_frame();
        push_frame();
        cpu_wr(CTRL, 32'h1, 4'h1);
        wait_pops(N, "frame1_done");
        cpu_rd(CTRL, d, h);
        check("ctrl_frame1", d, 32'h0000_0103);
        cpu_wr(CTRL, 32'h3, 4'h1);
        cpu_rd(CTRL, d, h);
        check("ctrl_w1c", d, 32'h0000_0101);
        n = 0;
        while (sof_cyc.size() < 2 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (sof_cyc.size() >= 2)
            check("sof_period", 32'(sof_cyc[1] - sof_cyc[0]), 32'(2*N + BLANK));
        else
            check("sof_seen", 32'(sof_cyc.size()), 32'd2);

        // Clear scan_en mid-frame: frame completes, then idle
        cpu_wr(CTRL, 32'h0, 4'h1);
        wait_pops(2*N, "frame2_done");
        repeat (BLANK + 4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_after_stop", 32'(pix_valid), 32'd0);
        end
        cpu_rd(CTRL, d, h);
        check("ctrl_frame2", d, 32'h0000_0202);
        check("queue_empty2", 32'(exp_q.size()), 32'd0);

        // Random contents and random partial-lane writes
        cpu_wr(CTRL, 32'h2, 4'h1);
        cpu_rd(CTRL, d, h);
        check("ctrl_clear", d, 32'h0000_0200);
        for (int w = 0; w < N / 4; w++)
            cpu_wr(FB + 32'(4*w), $urandom, 4'hF);
        for (int i = 0; i < 24; i++)
            cpu_wr(FB + 32'($urandom_range(N - 1)), $urandom, 4'($urandom_range(15)));
        for (int i = 0; i < 4; i++) begin
            n = $urandom_range(N / 4 - 1);
            cpu_rd(FB + 32'(4*n), d, h);
            check("rand_word", d, model_word(n));
        end

        // Random backpressure; W1C lands on the same edge as frame_done sets
        push_frame();
        ready_mode = 1;
        cpu_wr(CTRL, 32'h1, 4'h1);
        found = 0;
        n = 0;
        while (!found && n < 20000) begin
            @(negedge clk);
            n++;
            if (pix_valid && pix_ready && pix_x == 4'd15 && pix_y == 4'd15) begin
                cpu_adr = CTRL; cpu_wdata = 32'h2; cpu_be = 4'h1; cpu_we = 1'b1;
                @(negedge clk);
                cpu_we = 1'b0; cpu_be = 4'h0; cpu_adr = 32'h0;
                found = 1;
            end
        end
        check("last_pixel_seen", 32'(found), 32'd1);
        cpu_rd(CTRL, d, h);
        check("ctrl_set_wins", d, 32'h0000_0302);
        ready_mode = 0;
        repeat (BLANK + 4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_after_w1c", 32'(pix_valid), 32'd0);
        end
        check("queue_empty3", 32'(exp_q.size()), 32'd0);

        // Reset while presenting (3,7)
        ready_mode = 2;
        push_frame();
        base = pops;
        cpu_wr(CTRL, 32'h1, 4'h1);
        found = 0;
        n = 0;
        while (!found && n < 5000) begin
            @(negedge clk);
            n++;
            if (pix_valid && pix_x == 4'd7 && pix_y == 4'd3) found = 1;
        end
        check("stall_reached", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_valid", 32'(pix_valid), 32'd0);
        check("rst_async_sof", 32'(pix_sof), 32'd0);
        check("pops_before_rst", 32'(pops - base), 32'(3*COLS + 7));
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ready_mode = 0;
        cpu_rd(CTRL, d, h);
        check("ctrl_after_rst", d, 32'h0);

        // Restart: first pixel must be (0,0) with sof
        push_frame();
        base = pops;
        cpu_wr(CTRL, 32'h1, 4'h1);
        wait_pops(base + N / 2, "restart_half");
        cpu_wr(CTRL, 32'h0, 4'h1);
        wait_pops(base + N, "restart_frame");
        repeat (BLANK + 4) @(negedge clk);
        cpu_rd(CTRL, d, h);
        check("ctrl_restart", d, 32'h0000_0102);
        check("queue_empty4", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
